// File: rtl/vdp_pkg.sv
// Shared types and widths for the VDP command/data-port sequencer.
package vdp_pkg;

    localparam int unsigned VRAM_AW = 14;
    localparam int unsigned CRAM_AW = 5;
    localparam int unsigned REG_AW  = 4;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } acc_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } vdp_state_e;

endpackage

// File: rtl/vdp_cmd_ctrl.sv
// Turns decoded port strobes into VRAM/CRAM/register accesses: two-byte control
// commands, auto-incrementing access address and a one-byte VRAM read-ahead buffer.
module vdp_cmd_ctrl
    import vdp_pkg::*;
(
    input  logic               clk,
    input  logic               reset_L,
    input  logic               CSW_L,
    input  logic               CSR_L,
    input  logic               MODE,
    input  logic [7:0]         wr_data,
    output logic [7:0]         rd_buf,
    output logic               status_rd,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [7:0]         vram_rdata,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [7:0]         cram_wdata,
    output logic               cram_we,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_addr,
    output logic [7:0]         reg_wdata
);

    vdp_state_e         state_q, state_d;
    acc_code_e          code_q, code_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic               first_q, first_d;
    logic [7:0]         latch_q, latch_d;
    logic [7:0]         rd_buf_q, rd_buf_d;

    logic               vram_we_q, vram_we_d;
    logic               vram_re_q, vram_re_d;
    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]         vram_wdata_q, vram_wdata_d;
    logic               cram_we_q, cram_we_d;
    logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
    logic [7:0]         cram_wdata_q, cram_wdata_d;
    logic               reg_we_q, reg_we_d;
    logic [REG_AW-1:0]  reg_addr_q, reg_addr_d;
    logic [7:0]         reg_wdata_q, reg_wdata_d;
    logic               status_rd_q, status_rd_d;

    logic wr_stb;
    logic rd_stb;

    // A write strobe masks a simultaneous read strobe.
    assign wr_stb = ~CSW_L;
    assign rd_stb = ~CSR_L & CSW_L;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        addr_d       = addr_q;
        first_d      = first_q;
        latch_d      = latch_q;
        rd_buf_d     = rd_buf_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        cram_addr_d  = cram_addr_q;
        cram_wdata_d = cram_wdata_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        vram_we_d    = 1'b0;
        vram_re_d    = 1'b0;
        cram_we_d    = 1'b0;
        reg_we_d     = 1'b0;
        status_rd_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_stb && MODE) begin
                    if (!first_q) begin
                        latch_d     = wr_data;
                        addr_d[7:0] = wr_data;
                        first_d     = 1'b1;
                    end else begin
                        code_d  = acc_code_e'(wr_data[7:6]);
                        addr_d  = {wr_data[5:0], addr_q[7:0]};
                        first_d = 1'b0;
                        if (acc_code_e'(wr_data[7:6]) == VRAM_RD) begin
                            vram_re_d   = 1'b1;
                            vram_addr_d = {wr_data[5:0], addr_q[7:0]};
                            state_d     = FETCH;
                        end else if (acc_code_e'(wr_data[7:6]) == REG_WR) begin
                            reg_we_d    = 1'b1;
                            reg_addr_d  = wr_data[REG_AW-1:0];
                            reg_wdata_d = latch_q;
                        end
                    end
                end else if (wr_stb) begin
                    if (code_q == CRAM_WR) begin
                        cram_we_d    = 1'b1;
                        cram_addr_d  = addr_q[CRAM_AW-1:0];
                        cram_wdata_d = wr_data;
                    end else begin
                        vram_we_d    = 1'b1;
                        vram_addr_d  = addr_q;
                        vram_wdata_d = wr_data;
                    end
                    rd_buf_d = wr_data;
                    addr_d   = addr_q + 14'd1;
                    first_d  = 1'b0;
                end else if (rd_stb && MODE) begin
                    first_d     = 1'b0;
                    status_rd_d = 1'b1;
                end else if (rd_stb) begin
                    first_d     = 1'b0;
                    vram_re_d   = 1'b1;
                    vram_addr_d = addr_q;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                // vram_re is high this cycle; data lands next cycle.
                addr_d  = addr_q + 14'd1;
                state_d = FILL;
            end
            FILL: begin
                rd_buf_d = vram_rdata;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            code_q       <= VRAM_RD;
            addr_q       <= '0;
            first_q      <= 1'b0;
            latch_q      <= '0;
            rd_buf_q     <= '0;
            vram_we_q    <= 1'b0;
            vram_re_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            cram_we_q    <= 1'b0;
            cram_addr_q  <= '0;
            cram_wdata_q <= '0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            status_rd_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            addr_q       <= addr_d;
            first_q      <= first_d;
            latch_q      <= latch_d;
            rd_buf_q     <= rd_buf_d;
            vram_we_q    <= vram_we_d;
            vram_re_q    <= vram_re_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            cram_we_q    <= cram_we_d;
            cram_addr_q  <= cram_addr_d;
            cram_wdata_q <= cram_wdata_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            status_rd_q  <= status_rd_d;
        end
    end

    assign rd_buf     = rd_buf_q;
    assign status_rd  = status_rd_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_we    = vram_we_q;
    assign vram_re    = vram_re_q;
    assign cram_addr  = cram_addr_q;
    assign cram_wdata = cram_wdata_q;
    assign cram_we    = cram_we_q;
    assign reg_we     = reg_we_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;

endmodule
